// File: rtl/down_counter_ctrl_if.sv
// Control/status bundle for the iteration-budget down counter.
// The decoder control logic is the master; the counter is the slave.
interface down_counter_ctrl_if #(
  parameter int WIDTH = 2
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             condition_check;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output load, load_value, condition_check,
    input  count, zero, busy, done
  );

  modport slave (
    input  load, load_value, condition_check,
    output count, zero, busy, done
  );
endinterface

// File: rtl/down_counter_ctrl.sv
// Loadable iteration-budget down counter with IDLE/COUNT/DONE control FSM.
// busy/done decode the state register; zero is a compare on the count register.
module down_counter_ctrl #(
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  down_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             w_load_nonzero;
  logic             w_last_step;

  assign w_load_nonzero = (bus.load_value != '0);
  assign w_last_step    = (r_count == ONE);

  // COUNT is only ever entered with a nonzero count, so the decrement never underflows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.load) begin
            r_count <= bus.load_value;
            r_state <= w_load_nonzero ? COUNT : DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        COUNT: begin
          if (bus.load) begin
            r_count <= bus.load_value;
            r_state <= w_load_nonzero ? COUNT : DONE;
          end else if (bus.condition_check) begin
            r_count <= r_count - ONE;
            if (w_last_step) begin
              r_state <= DONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign bus.count = r_count;
  assign bus.zero  = (r_count == '0);
  assign bus.busy  = (r_state == COUNT);
  assign bus.done  = (r_state == DONE);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl: the stimulus pushes hand-computed
// expectations into a queue, a separate monitor pops and compares them.
module tb_down_counter_ctrl;

  localparam int WIDTH = 2;

  typedef struct {
    int         edge_n;
    int         id;
    logic [1:0] cnt;
    logic       z;
    logic       b;
    logic       d;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   step_id;
  exp_t sb[$];
  event chk_ev;

  down_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  down_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input int id, input string nm, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step%0d %s: got %b, expected %b", id, nm, act, req);
    end
  endtask

  // Monitor: pops every expectation whose clock edge has already occurred.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
        e = sb.pop_front();
        cmp(e.id, "count", bus.count, e.cnt);
        cmp(e.id, "zero", {1'b0, bus.zero}, {1'b0, e.z});
        cmp(e.id, "busy", {1'b0, bus.busy}, {1'b0, e.b});
        cmp(e.id, "done", {1'b0, bus.done}, {1'b0, e.d});
      end
    end
  end

  task automatic push(input int edge_n, input logic [1:0] ec, input logic eb, input logic ed);
    exp_t e;
    e.edge_n = edge_n;
    e.id     = step_id;
    e.cnt    = ec;
    e.z      = (ec == 2'b00);
    e.b      = eb;
    e.d      = ed;
    sb.push_back(e);
    step_id++;
  endtask

  // Called at a falling edge: drive inputs, expect the state after the next rising edge.
  task automatic step(input logic ld, input logic [1:0] lv, input logic cc,
                      input logic [1:0] ec, input logic eb, input logic ed);
    bus.load            = ld;
    bus.load_value      = lv;
    bus.condition_check = cc;
    push(cyc + 1, ec, eb, ed);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step_id  = 0;
    reset    = 1'b0;
    bus.load = 1'b0;
    bus.load_value = 2'b00;
    bus.condition_check = 1'b0;
    @(negedge clk);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'($urandom), 2'($urandom), 1'($urandom), 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);

    // Full countdown from 3
    step(1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Stall pattern 1,0,0,1
    step(1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Reload has priority over decrement
    step(1'b1, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Zero budget, reload of zero in DONE, then single-step countdown
    step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Nonzero load accepted during DONE
    step(1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset between edges while counting
    step(1'b1, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    push(cyc, 2'b00, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
